// File: rtl/ucdp_afifo_rd_pack.sv
// Read-side packer for ucdp_afifo: pops FWFT words and packs ratio_p of them,
// lane 0 first, into one registered valid/ready output word; flush closes a partial word.
module ucdp_afifo_rd_pack #(
    parameter int dwidth_p = 8,
    parameter int ratio_p  = 4,
    parameter int cwidth_p = $clog2(ratio_p + 1)
) (
    input  logic                         main_clk_i,
    input  logic                         main_rst_i,
    output logic                         fifo_rd_ena_o,
    input  logic                         fifo_rd_empty_i,
    input  logic [dwidth_p-1:0]          fifo_rd_data_i,
    input  logic                         flush_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [dwidth_p*ratio_p-1:0]  out_data_o,
    output logic [cwidth_p-1:0]          out_cnt_o,
    output logic                         busy_o
);

    logic [dwidth_p-1:0]          pack_r [ratio_p];
    logic [cwidth_p-1:0]          cnt_r;
    logic                         flush_r;
    logic                         out_valid_r;
    logic [dwidth_p*ratio_p-1:0]  out_data_r;
    logic [cwidth_p-1:0]          out_cnt_r;

    logic                         slot_free;
    logic                         flush_pend;
    logic                         last;
    logic                         pop;
    logic                         full_emit;
    logic                         flush_svc;
    logic                         emit;
    logic [cwidth_p-1:0]          n;
    logic [dwidth_p*ratio_p-1:0]  emit_data;

    assign slot_free  = !out_valid_r | out_ready_i;
    assign flush_pend = flush_i | flush_r;
    assign last       = (cnt_r == cwidth_p'(ratio_p - 1));
    assign pop        = !main_rst_i & !fifo_rd_empty_i &
                        (flush_pend ? slot_free : (!last | slot_free));
    assign n          = cnt_r + cwidth_p'(pop);
    assign full_emit  = pop & last & !flush_pend;
    assign flush_svc  = flush_pend & slot_free;
    assign emit       = full_emit | (flush_svc & (n != '0));

    // Collected lanes below cnt_r, the word being popped in lane cnt_r, zeros above.
    // A full emit is the same picture with cnt_r = ratio_p-1.
    always_comb begin
        emit_data = '0;
        for (int k = 0; k < ratio_p; k++) begin
            if (cwidth_p'(k) < cnt_r) begin
                emit_data[k*dwidth_p +: dwidth_p] = pack_r[k];
            end else if ((cwidth_p'(k) == cnt_r) && pop) begin
                emit_data[k*dwidth_p +: dwidth_p] = fifo_rd_data_i;
            end
        end
    end

    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            cnt_r       <= '0;
            flush_r     <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_cnt_r   <= '0;
            for (int k = 0; k < ratio_p; k++) begin
                pack_r[k] <= '0;
            end
        end else begin
            if (emit) begin
                out_valid_r <= 1'b1;
                out_data_r  <= emit_data;
                out_cnt_r   <= n;
                cnt_r       <= '0;
            end else begin
                if (out_ready_i) begin
                    out_valid_r <= 1'b0;
                end
                if (pop) begin
                    for (int k = 0; k < ratio_p; k++) begin
                        if (cwidth_p'(k) == cnt_r) begin
                            pack_r[k] <= fifo_rd_data_i;
                        end
                    end
                    cnt_r <= cnt_r + cwidth_p'(1);
                end
            end

            // A flush that cannot be served now is held until the slot frees.
            if (flush_svc) begin
                flush_r <= 1'b0;
            end else if (flush_pend) begin
                flush_r <= 1'b1;
            end
        end
    end

    assign fifo_rd_ena_o = pop;
    assign out_valid_o   = out_valid_r;
    assign out_data_o    = out_data_r;
    assign out_cnt_o     = out_cnt_r;
    assign busy_o        = (cnt_r != '0) | flush_pend | out_valid_r;

endmodule

// File: tb/tb_ucdp_afifo_rd_pack.sv
// Directed self-checking bench for ucdp_afifo_rd_pack (dwidth_p=8, ratio_p=4)
// with a small FWFT FIFO model driving the read port.
module tb_ucdp_afifo_rd_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_rd_ena;
    logic        fifo_rd_empty;
    logic [7:0]  fifo_rd_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_cnt;
    logic        busy;

    logic [7:0]  fifo_q [$];
    logic        en_s;
    int          total = 0;
    int          bad   = 0;

    ucdp_afifo_rd_pack #(.dwidth_p(8), .ratio_p(4)) dut (
        .main_clk_i      (clk),
        .main_rst_i      (rst),
        .fifo_rd_ena_o   (fifo_rd_ena),
        .fifo_rd_empty_i (fifo_rd_empty),
        .fifo_rd_data_i  (fifo_rd_data),
        .flush_i         (flush),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_data_o      (out_data),
        .out_cnt_o       (out_cnt),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    task automatic refreshFifo();
        fifo_rd_empty = (fifo_q.size() == 0);
        fifo_rd_data  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    endtask

    task automatic pushWord(input logic [7:0] w);
        fifo_q.push_back(w);
        refreshFifo();
    endtask

    // One clock: sample the pop strobe before the edge, advance the FIFO model after it.
    task automatic applyStimulus();
        #1;
        en_s = fifo_rd_ena;
        @(posedge clk);
        #1;
        if (en_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
        refreshFifo();
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic checkWord(input string tag, input logic [31:0] d, input logic [2:0] c);
        checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, "_data"}, 64'(out_data), 64'(d));
        checkOutput({tag, "_cnt"}, 64'(out_cnt), 64'(c));
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        en_s = 1'b0;
        refreshFifo();

        // Reset: FIFO already holds data, but nothing may be popped.
        for (int i = 1; i <= 8; i++) pushWord(8'(i * 8'h11));
        @(posedge clk);
        #1;
        applyStimulus();
        checkOutput("rst_ena", 64'(en_s), 64'd0);
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_data", 64'(out_data), 64'd0);
        checkOutput("rst_cnt", 64'(out_cnt), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;

        $display("[TB] stream packing");
        for (int i = 0; i < 8; i++) begin
            applyStimulus();
            checkOutput("stream_pop", 64'(en_s), 64'd1);
            if (i == 3) checkWord("stream_w0", 32'h44332211, 3'd4);
            if (i == 7) checkWord("stream_w1", 32'h88776655, 3'd4);
        end
        applyStimulus();
        checkOutput("stream_drain_valid", 64'(out_valid), 64'd0);
        checkOutput("stream_drain_busy", 64'(busy), 64'd0);

        $display("[TB] backpressure");
        for (int i = 1; i <= 8; i++) pushWord(8'(i));
        for (int i = 0; i < 4; i++) applyStimulus();
        checkWord("bp_w0", 32'h04030201, 3'd4);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput("bp_pop", 64'(en_s), (i < 3) ? 64'd1 : 64'd0);
            checkWord("bp_hold", 32'h04030201, 3'd4);
        end
        out_ready = 1'b1;
        applyStimulus();
        checkOutput("bp_release_pop", 64'(en_s), 64'd1);
        checkWord("bp_w1", 32'h08070605, 3'd4);
        applyStimulus();
        checkOutput("bp_drain_valid", 64'(out_valid), 64'd0);
        checkOutput("bp_fifo_left", 64'(fifo_q.size()), 64'd0);

        $display("[TB] partial flush");
        pushWord(8'hA1);
        pushWord(8'hA2);
        applyStimulus();
        applyStimulus();
        flush = 1'b1;
        applyStimulus();
        flush = 1'b0;
        checkWord("pf_word", 32'h0000A2A1, 3'd2);
        applyStimulus();
        checkOutput("pf_drain_valid", 64'(out_valid), 64'd0);
        checkOutput("pf_drain_busy", 64'(busy), 64'd0);
        flush = 1'b1;
        #1;
        checkOutput("pf_empty_flush_busy", 64'(busy), 64'd1);
        applyStimulus();
        flush = 1'b0;
        #1;
        checkOutput("pf_empty_flush_valid", 64'(out_valid), 64'd0);
        checkOutput("pf_empty_flush_busy_fall", 64'(busy), 64'd0);

        $display("[TB] flush with simultaneous pop");
        pushWord(8'hB1);
        applyStimulus();
        pushWord(8'hB2);
        flush = 1'b1;
        applyStimulus();
        flush = 1'b0;
        checkOutput("fp_pop", 64'(en_s), 64'd1);
        checkWord("fp_word", 32'h0000B2B1, 3'd2);
        applyStimulus();
        checkOutput("fp_drain_valid", 64'(out_valid), 64'd0);

        $display("[TB] blocked flush");
        for (int i = 1; i <= 5; i++) pushWord(8'(8'hC0 + i));
        for (int i = 0; i < 4; i++) applyStimulus();
        checkWord("bf_w0", 32'hC4C3C2C1, 3'd4);
        out_ready = 1'b0;
        applyStimulus();
        checkOutput("bf_pop_c5", 64'(en_s), 64'd1);
        pushWord(8'hC6);
        flush = 1'b1;
        applyStimulus();
        flush = 1'b0;
        checkOutput("bf_blocked_pop", 64'(en_s), 64'd0);
        applyStimulus();
        checkOutput("bf_blocked_pop2", 64'(en_s), 64'd0);
        checkOutput("bf_blocked_busy", 64'(busy), 64'd1);
        checkWord("bf_hold", 32'hC4C3C2C1, 3'd4);
        out_ready = 1'b1;
        applyStimulus();
        checkOutput("bf_release_pop", 64'(en_s), 64'd1);
        checkWord("bf_word", 32'h0000C6C5, 3'd2);
        applyStimulus();
        checkOutput("bf_drain_valid", 64'(out_valid), 64'd0);
        checkOutput("bf_drain_busy", 64'(busy), 64'd0);

        $display("[TB] reset mid-operation");
        for (int i = 1; i <= 6; i++) pushWord(8'(8'hD0 + i));
        for (int i = 0; i < 4; i++) applyStimulus();
        checkWord("rm_w0", 32'hD4D3D2D1, 3'd4);
        out_ready = 1'b0;
        applyStimulus();
        applyStimulus();
        pushWord(8'hD7);
        rst = 1'b1;
        #1;
        checkOutput("rm_ena_in_reset", 64'(fifo_rd_ena), 64'd0);
        applyStimulus();
        checkOutput("rm_ena_sampled", 64'(en_s), 64'd0);
        checkOutput("rm_valid", 64'(out_valid), 64'd0);
        checkOutput("rm_data", 64'(out_data), 64'd0);
        checkOutput("rm_cnt", 64'(out_cnt), 64'd0);
        checkOutput("rm_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        pushWord(8'hE2);
        pushWord(8'hE3);
        pushWord(8'hE4);
        for (int i = 0; i < 4; i++) applyStimulus();
        checkWord("rm_restart", 32'hE4E3E2D7, 3'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ucdp_afifo_rd_pack.md
# ucdp_afifo_rd_pack

Read-side packer that sits directly downstream of `ucdp_afifo`, on the clk1 side. It pops `dwidth_p`-bit words from the FIFO's first-word-fall-through read port and packs `ratio_p` consecutive words, LSB-lane first, into one `dwidth_p*ratio_p`-bit output word. The output is a registered valid/ready stream. A flush request closes a partially filled word and emits it with a word count.

## Interface

Parameters:
- `dwidth_p`, default 8: FIFO word width; equals `ucdp_afifo` `dwidth_p`.
- `ratio_p`, default 4: FIFO words per output word; range 2..16.
- `cwidth_p`, default `$clog2(ratio_p+1)`: width of the count fields.

Ports:
- Reset is synchronous and active-high; one clock.
- `main_clk_i`  in  1  clock; same clock as the FIFO's clk1 domain.
- `main_rst_i`  in  1  synchronous, active-high reset.
- `fifo_rd_ena_o`  out  1  pop strobe; connects to `clk1_rd_ena_i`.
- `fifo_rd_empty_i`  in  1  from `clk1_rd_empty_o`.
- `fifo_rd_data_i`  in  `dwidth_p`  from `clk1_rd_data_o`; valid whenever `!fifo_rd_empty_i`.
- `flush_i`  in  1  single-cycle pulse; requests emission of the current partial word.
- `out_valid_o`  out  1  output word valid.
- `out_ready_i`  in  1  consumer accepts the word.
- `out_data_o`  out  `dwidth_p*ratio_p`  packed word; lane k is `[k*dwidth_p +: dwidth_p]`.
- `out_cnt_o`  out  `cwidth_p`  number of valid lanes, 1..`ratio_p`; lanes at or above `out_cnt_o` are zero.
- `busy_o`  out  1  high when `cnt_r!=0`, `flush_pend` is high, or `out_valid_o` is high.

## Operation

State:
- Pack register `pack_r[ratio_p-1:0]`, one `dwidth_p` lane each.
- `cnt_r`, range 0..`ratio_p-1`: number of lanes collected.
- `flush_r`: registered flush request.
- Output registers: `out_valid_r`, `out_data_r`, `out_cnt_r`.

Derived signals:
- `slot_free = !out_valid_r | out_ready_i`
- `flush_pend = flush_i | flush_r`
- `last = (cnt_r == ratio_p-1)`

Pop rule (combinational):
- `pop = !main_rst_i & !fifo_rd_empty_i & (flush_pend ? slot_free : (!last | slot_free))`.
- `fifo_rd_ena_o = pop`.
- There is a combinational path from `out_ready_i` and `fifo_rd_empty_i` to `fifo_rd_ena_o`. This path is intentional.

Per clock edge, when not in reset:
- **Pop without emit:** when `pop` is high and there is no emit, store `fifo_rd_data_i` into lane `cnt_r` and set `cnt_r <= cnt_r+1`.
- **Full emit:** when `pop & last & !flush_pend`:
  - `out_data_r` = pack lanes 0..`ratio_p-2` plus `fifo_rd_data_i` in lane `ratio_p-1`.
  - `out_cnt_r = ratio_p`, `out_valid_r = 1`, `cnt_r <= 0`.
- **Flush service:** when `flush_pend & slot_free`:
  - `n = cnt_r + pop`.
  - If `n > 0`: emit lanes 0..`cnt_r-1`, plus `fifo_rd_data_i` in lane `cnt_r` if `pop`. Other lanes are 0. Set `out_cnt_r = n`, `out_valid_r = 1`, `cnt_r <= 0`.
  - If `n == 0`: no output.
  - In both cases `flush_r <= 0`.
- **Flush blocked:** when `flush_pend & !slot_free`, set `flush_r <= 1`. No pops occur while blocked.
- **Handshake:**
  - `out_valid_r` clears when `out_ready_i` is high and no new emit happens in the same cycle.
  - An emit in the same cycle as `out_ready_i` replaces the word with no bubble.
  - While `out_valid_o & !out_ready_i`, `out_data_o` and `out_cnt_o` are held stable.
- **Repeated flush:** `flush_i` asserted while `flush_r` is already set merges into a single flush.

Reset (`main_rst_i` high at an edge):
- All registers go to zero: `cnt_r`, `flush_r`, `out_valid_r`, `out_data_r`, `out_cnt_r`, `pack_r`.
- `fifo_rd_ena_o` is forced to 0 while `main_rst_i` is high.
- Reset in mid-pack discards the collected lanes and any pending output word. No FIFO pop occurs in the reset cycle.

## Timing

- Output reset values:
  - `out_valid_o = 0`, `out_data_o = 0`, `out_cnt_o = 0`, `busy_o = 0`.
  - `fifo_rd_ena_o = 0` while in reset.
- Latency: the word that completes a pack, or is popped in a flush-service cycle, appears on `out_data_o` one edge after its pop.
- Throughput:
  - One FIFO word per cycle sustained when `out_ready_i` is held high.
  - One output word per `ratio_p` cycles at steady state.
- Backpressure: with the output slot full and `out_ready_i` low, the packer stalls at `cnt_r = ratio_p-1` with `fifo_rd_ena_o = 0`.
- A flush with an empty pack and an empty FIFO completes in 1 cycle with no output.

## Test plan

- **Stream packing:** `ratio_p=4`, FIFO supplies 0x11,0x22,0x33,0x44,0x55..0x88 back-to-back, `out_ready_i=1`.
  - Expect `out_data_o=0x44332211`, cnt 4, then `0x88776655`, cnt 4.
  - Expect `fifo_rd_ena_o` high for 8 consecutive cycles.
- **Backpressure:** hold `out_ready_i=0` after the first word is emitted.
  - Expect 3 more pops, then `fifo_rd_ena_o=0`, with `out_data_o` stable.
  - Release ready: next word emitted one edge later with no lost or duplicated data.
- **Partial flush:** push 0xA1,0xA2, then pulse `flush_i` with the FIFO empty.
  - Expect `out_data_o=0x0000A2A1`, `out_cnt_o=2`.
  - Then a flush with `cnt_r=0` produces no output and `busy_o` falls.
- **Flush with simultaneous pop:** `cnt_r=1` (0xB1), pulse `flush_i` while the FIFO presents 0xB2.
  - Expect one pop, output `0x0000B2B1`, cnt 2.
- **Blocked flush:** pulse `flush_i` while `out_valid_o=1` and `out_ready_i=0`.
  - Expect `flush_r` held and no pops.
  - On ready: pending word accepted and partial word emitted in the same edge.
- **Reset mid-operation:** assert `main_rst_i` at `cnt_r=2` with an output pending.
  - Expect all outputs zero at the next edge, `fifo_rd_ena_o=0` during reset, and packing restarting at lane 0 afterwards.
